// File: rtl/bp_fe_queue_fifo.sv
// rtl/bp_fe_queue_fifo.sv - replayable FE-to-scheduler queue with speculative read and commit pointers
module bp_fe_queue_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);
    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;
    localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] cptr_q, cptr_d;
    logic [ptr_w_lp-1:0] cptr_n;
    logic [width_p-1:0]  mem_q [els_p];
    logic                full;
    logic                enq;

    // Occupancy counts from the commit pointer: issued-but-uncommitted slots stay allocated.
    assign full             = (wptr_q - cptr_q) == els_lp;
    assign fe_queue_ready_o = reset_n_i & ~full & ~fe_queue_clr_i;
    assign fe_queue_v_o     = reset_n_i & (rptr_q != wptr_q);
    assign fe_queue_o       = mem_q[rptr_q[idx_w_lp-1:0]];
    assign enq              = fe_queue_v_i & fe_queue_ready_o;

    always_comb begin
        cptr_n = cptr_q + {{(ptr_w_lp-1){1'b0}}, fe_queue_deq_i};
        cptr_d = cptr_n;
        wptr_d = wptr_q + {{(ptr_w_lp-1){1'b0}}, enq};
        rptr_d = rptr_q + {{(ptr_w_lp-1){1'b0}}, fe_queue_yumi_i};
        if (fe_queue_clr_i) begin
            rptr_d = cptr_n;
            wptr_d = cptr_n;
        end else if (fe_queue_roll_i) begin
            rptr_d = cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[idx_w_lp-1:0]] <= fe_queue_i;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_yumi_i && !fe_queue_v_o));
    a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_deq_i && (cptr_q == rptr_q)));
endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// tb/tb_bp_fe_queue_fifo.sv - randomized and directed bench for bp_fe_queue_fifo against a queue model
module tb_bp_fe_queue_fifo;
    localparam int EL = 8;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         v_i, yumi, deq, roll, clr;
    logic         ready_o, v_o;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    int           issued = 0;
    bit           started = 1'b0;
    int           tag = 0;
    int           accepted = 0;

    always #5 clk = ~clk;

    bp_fe_queue_fifo #(.els_p(EL), .width_p(W)) dut (
        .clk_i           (clk),
        .reset_n_i       (rst_n),
        .fe_queue_i      (din),
        .fe_queue_v_i    (v_i),
        .fe_queue_ready_o(ready_o),
        .fe_queue_o      (dout),
        .fe_queue_v_o    (v_o),
        .fe_queue_yumi_i (yumi),
        .fe_queue_deq_i  (deq),
        .fe_queue_roll_i (roll),
        .fe_queue_clr_i  (clr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return rst_n && (mq.size() < EL) && !clr;
    endfunction

    // Queue holds every entry from the oldest uncommitted one; 'issued' counts the speculatively consumed prefix.
    task automatic model_update();
        bit acc;
        if (!rst_n) begin
            mq.delete();
            issued  = 0;
            started = 1'b1;
        end else if (started) begin
            acc = v_i && m_ready();
            if (deq) begin
                void'(mq.pop_front());
                issued--;
            end
            if (clr) begin
                mq.delete();
                issued = 0;
            end else begin
                if (roll) issued = 0;
                else if (yumi) issued++;
                if (acc) begin
                    mq.push_back(din);
                    accepted++;
                    tag++;
                end
            end
        end
    endtask

    task automatic set_in(input bit v, input int d, input bit y, input bit dq, input bit rl, input bit cl);
        v_i  = v;
        din  = W'(d);
        yumi = y;
        deq  = dq;
        roll = rl;
        clr  = cl;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always begin
        @(negedge clk);
        if (started) begin
            chk("ready", 32'(ready_o), 32'(m_ready()));
            chk("valid", 32'(v_o), 32'(rst_n && (issued < mq.size())));
            if (rst_n && issued < mq.size()) chk("data", 32'(dout), 32'(mq[issued]));
        end
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("rst_v_lit", 32'(v_o), 0);
        chk("rst_ready_lit", 32'(ready_o), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_lit", 32'(ready_o), 1);
        chk("rel_v_lit", 32'(v_o), 0);

        // Fill with tags 0..7, then a 9th valid must be held off.
        for (int i = 0; i < EL; i++) begin
            set_in(1, tag, 0, 0, 0, 0);
            step();
        end
        set_in(1, tag, 0, 0, 0, 0);
        @(negedge clk);
        chk("fill_ready_lit", 32'(ready_o), 0);
        chk("fill_head_lit", 32'(dout), 0);
        step();
        chk("fill_held_lit", 32'(tag), 8);

        // Roll replay after issuing tags 0,1,2.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("roll_head_lit", 32'(dout), 0);
        chk("roll_v_lit", 32'(v_o), 1);

        // Issue 0..3, commit twice, then roll with a third commit.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 1, 0, 0);
            step();
        end
        set_in(0, 0, 0, 1, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pcroll_head_lit", 32'(dout), 3);
        for (int i = 0; i < 2; i++) begin
            set_in(1, tag, 0, 0, 0, 0);
            step();
        end
        chk("pcroll_enq_lit", 32'(tag), 10);

        // Clear from an empty queue, then 5 entries, 2 issued, 1 committed.
        set_in(0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(1, tag, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 1, 0, 0);
        step();
        set_in(1, 16'h0bad, 0, 0, 0, 1);
        @(negedge clk);
        chk("clr_ready_lit", 32'(ready_o), 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_v_lit", 32'(v_o), 0);
        chk("clr_ready_after_lit", 32'(ready_o), 1);
        set_in(1, 16'h0a5a, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_next_lit", 32'(dout), 32'h0a5a);

        // Wrap streaming: 40 entries with yumi and deq every legal cycle.
        set_in(0, 0, 0, 0, 0, 1);
        step();
        accepted = 0;
        for (int c = 0; c < 400 && accepted < 40; c++) begin
            set_in($urandom_range(0, 3) != 0, 16'h1000 + tag, issued < mq.size(), issued > 0, 0, 0);
            step();
        end
        chk("stream_accepted", 32'(accepted), 40);

        // Randomized mix of rolls and clears.
        for (int c = 0; c < 1500; c++) begin
            bit cl, rl;
            cl = ($urandom_range(0, 59) == 0);
            rl = !cl && ($urandom_range(0, 29) == 0);
            set_in($urandom_range(0, 9) < 7, $urandom, (issued < mq.size()) && ($urandom_range(0, 3) != 0),
                   (issued > 0) && ($urandom_range(0, 2) != 0), rl, cl);
            step();
        end

        // Reset with 6 entries resident.
        set_in(0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 16'h2000 + i, 0, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_v_lit", 32'(v_o), 0);
        chk("mid_rst_ready_lit", 32'(ready_o), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready_lit", 32'(ready_o), 1);
        chk("mid_rel_v_lit", 32'(v_o), 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
